ecc_result_collector: RTL
=========================

ECC_RESULT_COLLECTOR -- requirements
Module: ecc_result_collector

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, the number of 4-bit result nibbles per word (word width = 4*NIBBLES).
REQ-002 SHALL have parameter LAT, default 1, the cycles from the done pulse to the first result nibble (legal range 0..7).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port done, input, 1, one-cycle pulse from the ECC lookup engine marking the start of a result burst.
REQ-006 SHALL have port kPx, input, 4, x-coordinate result nibble, LSB nibble first.
REQ-007 SHALL have port kPy, input, 4, y-coordinate result nibble, LSB nibble first.
REQ-008 SHALL have port out_x, output, 4*NIBBLES, assembled x coordinate.
REQ-009 SHALL have port out_y, output, 4*NIBBLES, assembled y coordinate.
REQ-010 SHALL have port out_valid, output, 1, out_x/out_y hold an unconsumed result.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result when out_valid && out_ready at a rising edge.
REQ-012 SHALL have port busy, output, 1, high in states DELAY and CAPTURE.
REQ-013 SHALL have port overflow, output, 1, sticky: a completed result was dropped.
REQ-014 SHALL have port protocol_err, output, 1, sticky: done was seen during DELAY or CAPTURE.

Function
REQ-015 SHALL implement the states IDLE, DELAY and CAPTURE, with IDLE as the reset state.
REQ-016 IDLE: done=1 SHALL go to DELAY with the delay counter loaded to LAT-1 when LAT>0, or go straight to CAPTURE and sample nibble 0 on the following cycle when LAT=0.
REQ-017 DELAY: the delay counter SHALL decrement each cycle, and the block SHALL enter CAPTURE after the count reaches 0, so that nibble 0 is sampled exactly LAT+1 edges after the edge that registered done.
REQ-018 CAPTURE: each cycle SHALL write kPx/kPy into nibble slot i of the shadow registers, with i running 0..NIBBLES-1, so nibble i lands in bits [4i+3:4i].
REQ-019 After slot NIBBLES-1 is written the block SHALL return to IDLE and raise a one-cycle internal "complete".
REQ-020 On complete with out_valid=0, or with out_valid=1 && out_ready=1 in the same cycle, the shadow SHALL be copied to out_x/out_y and out_valid set to 1 on the next edge.
REQ-021 On complete with out_valid=1 && out_ready=0, the new result SHALL be dropped, out_x/out_y/out_valid left unchanged, and overflow set to 1.
REQ-022 An accept (out_valid && out_ready) without a simultaneous complete SHALL clear out_valid on the next edge.
REQ-023 out_x/out_y SHALL stay stable while out_valid=1.
REQ-024 done during DELAY or CAPTURE SHALL be ignored for sequencing (the burst continues) and SHALL set protocol_err.
REQ-025 done in the same cycle that complete fires SHALL be treated as an IDLE-state done (a new burst starts) and SHALL NOT set protocol_err.
REQ-026 The slot index SHALL be ceil(log2(NIBBLES)) bits wide and SHALL NOT wrap during a burst.
REQ-027 The block SHALL perform no arithmetic on the data; the nibbles SHALL be passed through unmodified.
REQ-028 busy SHALL be a registered decode of the state, so it equals 0 in IDLE.

Reset
REQ-029 While reset=1 at an edge, the block SHALL force state=IDLE, the counters to 0, out_x=0, out_y=0, out_valid=0, busy=0, overflow=0 and protocol_err=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no partial result ever reaching out_x/out_y.
REQ-031 Reset SHALL take priority over done and out_ready in the same cycle.
REQ-032 The shadow registers SHALL NOT require a reset value.

Verification
REQ-033 Basic capture, LAT=1, NIBBLES=8, out_ready=1: done pulse, then nibbles x=8,7,6,5,4,3,2,1 and y=0..7 -> out_x=32'h12345678, out_y=32'h76543210, out_valid=1 for exactly one cycle, 10 edges after done.
REQ-034 Back-pressure: out_ready=0, first burst completes, then a second burst completes -> out_x keeps the first value, overflow=1; raising out_ready then clears out_valid.
REQ-035 Simultaneous accept and complete: out_valid=1 and out_ready=1 in the complete cycle -> the new word is loaded, out_valid stays 1, overflow stays 0.
REQ-036 Protocol error: done re-pulsed in CAPTURE at slot 3 -> the burst completes with its original nibbles and protocol_err=1.
REQ-037 Reset mid-burst: reset at slot 4 -> out_valid=0 and out_x=0; a fresh burst afterwards assembles correctly.
REQ-038 LAT=0 build: nibble 0 presented on the cycle after done -> correct assembly.

Source files
------------

// File: rtl/ecc_result_collector_if.sv
// Bundle between the ECC lookup engine, the result collector and the result consumer.
// The slave side is the collector; the master side drives done/nibbles and out_ready.
interface ecc_result_collector_if #(
  parameter int NIBBLES = 8
);
  logic                   done;
  logic [3:0]             kPx;
  logic [3:0]             kPy;
  logic [4*NIBBLES-1:0]   out_x;
  logic [4*NIBBLES-1:0]   out_y;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output done, kPx, kPy, out_ready,
    input  out_x, out_y, out_valid
  );

  modport slave (
    input  done, kPx, kPy, out_ready,
    output out_x, out_y, out_valid
  );
endinterface

// File: rtl/ecc_result_collector.sv
// Assembles LSB-first x/y result nibbles from the ECC engine into full words and
// presents them through a single-entry valid/ready output register.
module ecc_result_collector #(
  parameter int NIBBLES = 8,
  parameter int LAT     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  ecc_result_collector_if.slave bus,
  output logic                 busy,
  output logic                 overflow,
  output logic                 protocol_err
);
  localparam int                W         = 4 * NIBBLES;
  localparam int                SLOT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NIBBLES - 1);
  localparam logic [2:0]        CNT_INIT  = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                complete_q, complete_d;
  logic [W-1:0]        shadow_x_q, shadow_x_d;
  logic [W-1:0]        shadow_y_q, shadow_y_d;
  logic [W-1:0]        out_x_q, out_x_d;
  logic [W-1:0]        out_y_q, out_y_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic                protocol_err_q, protocol_err_d;
  logic                start_burst;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    slot_d         = slot_q;
    complete_d     = 1'b0;
    shadow_x_d     = shadow_x_q;
    shadow_y_d     = shadow_y_q;
    protocol_err_d = protocol_err_q;
    start_burst    = 1'b0;

    case (state_q)
      IDLE: begin
        start_burst = bus.done;
      end
      DELAY: begin
        protocol_err_d = protocol_err_q | bus.done;
        if (cnt_q == 3'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CAPTURE: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (slot_q == SLOT_W'(i)) begin
            shadow_x_d[4*i +: 4] = bus.kPx;
            shadow_y_d[4*i +: 4] = bus.kPy;
          end
        end
        if (slot_q == LAST_SLOT) begin
          // A done arriving as the burst closes begins the next burst cleanly.
          complete_d  = 1'b1;
          slot_d      = '0;
          state_d     = IDLE;
          start_burst = bus.done;
        end else begin
          slot_d         = slot_q + 1'b1;
          protocol_err_d = protocol_err_q | bus.done;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_burst) begin
      if (LAT == 0) begin
        state_d = CAPTURE;
      end else begin
        state_d = DELAY;
        cnt_d   = CNT_INIT;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // Single-entry output slot: a completed word is dropped rather than overwriting an unconsumed one.
  always_comb begin
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    if (complete_q) begin
      if (!out_valid_q || bus.out_ready) begin
        out_x_d     = shadow_x_q;
        out_y_d     = shadow_y_q;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 3'd0;
      slot_q         <= '0;
      complete_q     <= 1'b0;
      out_x_q        <= '0;
      out_y_q        <= '0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      slot_q         <= slot_d;
      complete_q     <= complete_d;
      out_x_q        <= out_x_d;
      out_y_q        <= out_y_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      overflow_q     <= overflow_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // Shadow contents only reach the outputs through complete_q, so they need no reset.
  always_ff @(posedge clk) begin
    shadow_x_q <= shadow_x_d;
    shadow_y_q <= shadow_y_d;
  end

  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign protocol_err  = protocol_err_q;
endmodule
